// File: rtl/threshold_reset_scheduler.sv
// rtl/threshold_reset_scheduler.sv - event counter with threshold-triggered, fixed-latency clear
module threshold_reset_scheduler #(
    parameter int CNT_W       = 4,
    parameter int RESET_DELAY = 2,
    parameter int THR_INIT    = 8,
    parameter int EVT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             soft_clr,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_threshold,
    output logic             cfg_ready,
    output logic [CNT_W-1:0] count,
    output logic             over,
    output logic             clr,
    output logic             wrap,
    output logic             inc_drop,
    output logic [EVT_W-1:0] clr_events
);

    typedef enum logic {RUN, PEND} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THR_RST  = CNT_W'(THR_INIT);
    localparam logic [3:0]       DELAY_M1 = 4'(RESET_DELAY - 1);
    localparam logic [EVT_W-1:0] EVT_MAX  = '1;

    state_t           state, state_nxt;
    logic [3:0]       timer, timer_nxt;
    logic [CNT_W-1:0] threshold;
    logic [CNT_W-1:0] count_nxt;
    logic             wrap_nxt;
    logic             drop_nxt;
    logic             evt_inc;
    logic             cfg_fire;

    assign over      = (state == RUN) && (count > threshold);
    assign clr       = (state == RUN) ? (over && (RESET_DELAY == 1)) : (timer == 4'd1);
    assign cfg_ready = !rst && (state == RUN) && !over && !soft_clr;
    assign cfg_fire  = cfg_valid && cfg_ready;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        count_nxt = count;
        wrap_nxt  = 1'b0;
        drop_nxt  = 1'b0;
        evt_inc   = 1'b0;
        if (soft_clr) begin
            state_nxt = RUN;
            timer_nxt = 4'd0;
            count_nxt = '0;
        end else if (state == RUN) begin
            if (over) begin
                // The over cycle already freezes the counter, so its inc is dropped too.
                drop_nxt = inc;
                if (RESET_DELAY == 1) begin
                    count_nxt = '0;
                    evt_inc   = 1'b1;
                end else begin
                    state_nxt = PEND;
                    timer_nxt = DELAY_M1;
                end
            end else if (inc) begin
                count_nxt = count + 1'b1;
                wrap_nxt  = (count == CNT_MAX);
            end
        end else begin
            drop_nxt  = inc;
            timer_nxt = timer - 4'd1;
            if (timer == 4'd1) begin
                count_nxt = '0;
                state_nxt = RUN;
                evt_inc   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            timer      <= 4'd0;
            count      <= '0;
            threshold  <= THR_RST;
            wrap       <= 1'b0;
            inc_drop   <= 1'b0;
            clr_events <= '0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            count    <= count_nxt;
            wrap     <= wrap_nxt;
            inc_drop <= drop_nxt;
            if (cfg_fire)
                threshold <= cfg_threshold;
            if (evt_inc && (clr_events != EVT_MAX))
                clr_events <= clr_events + 1'b1;
        end
    end

endmodule

// File: tb/tb_threshold_reset_scheduler.sv
// tb/tb_threshold_reset_scheduler.sv - cycle-table bench for threshold_reset_scheduler
module tb_threshold_reset_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       inc = 1'b0;
    logic       soft_clr = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_threshold = 4'd0;
    logic       cfg_ready;
    logic [3:0] count;
    logic       over;
    logic       clr;
    logic       wrap;
    logic       inc_drop;
    logic [7:0] clr_events;

    threshold_reset_scheduler #(
        .CNT_W(4), .RESET_DELAY(2), .THR_INIT(8), .EVT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .inc(inc), .soft_clr(soft_clr),
        .cfg_valid(cfg_valid), .cfg_threshold(cfg_threshold), .cfg_ready(cfg_ready),
        .count(count), .over(over), .clr(clr), .wrap(wrap),
        .inc_drop(inc_drop), .clr_events(clr_events)
    );

    always #5 clk = ~clk;

    // One row per cycle: inputs driven in that cycle and outputs expected in that cycle (-1 = skip).
    typedef struct {
        logic       rst, inc, sc, cv;
        logic [3:0] thr;
        int         cnt, ov, cl, rd, wr, dr, ev;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(logic r, logic i, logic s, logic c, logic [3:0] t,
                                int cnt, int ov, int cl, int rd, int wr, int dr, int ev);
        vec_t v;
        v.rst = r; v.inc = i; v.sc = s; v.cv = c; v.thr = t;
        v.cnt = cnt; v.ov = ov; v.cl = cl; v.rd = rd; v.wr = wr; v.dr = dr; v.ev = ev;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int row, input int act, input int exp);
        if (exp >= 0) begin
            n_cmp++;
            if (act != exp) begin
                n_bad++;
                $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
            end
        end
    endtask

    initial begin
        vec_t v, e;
        int   sat;

        // Reset: first cycle registers are unknown, then reset values.
        add(1, 0, 0, 0, 0, -1, -1, -1, 0, -1, -1, -1);
        add(1, 0, 0, 0, 0,  0,  0,  0, 0,  0,  0,  0);
        add(1, 0, 0, 0, 0,  0,  0,  0, 0,  0,  0,  0);
        // THR_INIT=8, inc every cycle: over at 9, clr one cycle later, zero two cycles later.
        for (int k = 0; k <= 8; k++) add(0, 1, 0, 0, 0, k, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 9, 0, 1, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1);
        // Config held through over and PEND; accepted in first RUN cycle, then over at 4.
        for (int k = 1; k <= 8; k++) add(0, 1, 0, 0, 0, k, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 3, 9, 1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 3, 9, 0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 1, 3, 0, 0, 0, 1, 0, 0, 2);
        add(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2);
        add(0, 1, 0, 0, 0, 2, 0, 0, 1, 0, 0, 2);
        add(0, 1, 0, 0, 0, 3, 0, 0, 1, 0, 0, 2);
        add(0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0, 2);
        // Threshold 15: free wrap, single wrap pulse, no clears.
        add(0, 0, 0, 1, 15, 0, 0, 0, 1, 0, 0, 3);
        for (int k = 0; k <= 15; k++) add(0, 1, 0, 0, 0, k, 0, 0, 1, 0, 0, 3);
        add(0, 0, 0, 1, 8, 0, 0, 0, 1, 1, 0, 3);
        // soft_clr in the PEND cycle beats the scheduled clear and the same-cycle inc.
        for (int k = 0; k <= 8; k++) add(0, 1, 0, 0, 0, k, 0, 0, 1, 0, 0, 3);
        add(0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 3);
        add(0, 1, 1, 0, 0, 9, 0, 1, 0, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, -1, 3);
        // rst during PEND aborts the clear without counting it.
        for (int k = 0; k <= 8; k++) add(0, 1, 0, 0, 0, k, 0, 0, 1, 0, 0, 3);
        add(0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 3);
        add(1, 0, 0, 0, 0, 9, 0, 1, 0, 0, 0, 3);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        // Threshold 0: one clear every three cycles, event counter saturates at 255.
        for (int n = 1; n <= 300; n++) begin
            sat = (n - 1 > 255) ? 255 : n - 1;
            add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, sat);
            add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, sat);
            add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, sat);
        end
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 255);

        for (int r = 0; r < tbl.size(); r++) begin
            v = tbl[r];
            @(posedge clk);
            #1;
            rst = v.rst; inc = v.inc; soft_clr = v.sc;
            cfg_valid = v.cv; cfg_threshold = v.thr;
            exp_q.push_back(v);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL scoreboard row %0d: got empty queue expected 1 entry", r);
            end else begin
                e = exp_q.pop_front();
                chk("count",      r, int'(count),      e.cnt);
                chk("over",       r, int'(over),       e.ov);
                chk("clr",        r, int'(clr),        e.cl);
                chk("cfg_ready",  r, int'(cfg_ready),  e.rd);
                chk("wrap",       r, int'(wrap),       e.wr);
                chk("inc_drop",   r, int'(inc_drop),   e.dr);
                chk("clr_events", r, int'(clr_events), e.ev);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
